// File: rtl/mul_hilo_unit.sv
// Multicycle HI/LO control stage around an external combinational signed multiplier.
// Define MUL_MADD_EN to add the MADD (multiply-accumulate into {hi,lo}) operation.
module mul_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int LAT   = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [2:0]                op,
   input  logic [WIDTH-1:0]          src_a,
   input  logic [WIDTH-1:0]          src_b,
   output logic [WIDTH-1:0]          mul_a,
   output logic [WIDTH-1:0]          mul_b,
   input  logic signed [2*WIDTH-1:0] mul_c,
   output logic                      busy,
   output logic                      done,
   output logic [WIDTH-1:0]          hi,
   output logic [WIDTH-1:0]          lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MTHI  = 3'b001;
   localparam logic [2:0] OP_MTLO  = 3'b010;
`ifdef MUL_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'b011;
`endif
   localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

   state_e                    state_q, state_d;
   logic [3:0]                cnt_q, cnt_d;
   logic [WIDTH-1:0]          mul_a_q, mul_a_d;
   logic [WIDTH-1:0]          mul_b_q, mul_b_d;
   logic [WIDTH-1:0]          hi_q, hi_d;
   logic [WIDTH-1:0]          lo_q, lo_d;
   logic [2*WIDTH-1:0]        capture;

`ifdef MUL_MADD_EN
   logic                      madd_q, madd_d;

   // Accumulate wraps modulo 2^(2*WIDTH); two's complement makes signed and unsigned sums identical.
   function automatic logic [2*WIDTH-1:0] acc_wrap(input logic [2*WIDTH-1:0] acc,
                                                   input logic signed [2*WIDTH-1:0] prod);
      acc_wrap = acc + prod;
   endfunction

   assign capture = madd_q ? acc_wrap({hi_q, lo_q}, mul_c) : mul_c;
`else
   assign capture = mul_c;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MUL_MADD_EN
      madd_d  = madd_q;
`endif
      case (state_q)
         S_CALC: begin
            // mul_c is only trusted on the final count; earlier cycles let it settle.
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               {hi_d, lo_d} = capture;
               state_d      = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            if (start) begin
               case (op)
                  OP_MULT: begin
                     mul_a_d = src_a;
                     mul_b_d = src_b;
                     cnt_d   = CNT_INIT;
                     state_d = S_CALC;
`ifdef MUL_MADD_EN
                     madd_d  = 1'b0;
`endif
                  end
`ifdef MUL_MADD_EN
                  OP_MADD: begin
                     mul_a_d = src_a;
                     mul_b_d = src_b;
                     cnt_d   = CNT_INIT;
                     state_d = S_CALC;
                     madd_d  = 1'b1;
                  end
`endif
                  OP_MTHI: hi_d = src_a;
                  OP_MTLO: lo_d = src_a;
                  default: ;
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MUL_MADD_EN
         madd_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MUL_MADD_EN
         madd_q  <= madd_d;
`endif
      end
   end

   assign mul_a = mul_a_q;
   assign mul_b = mul_b_q;
   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = (state_q == S_CALC);
   assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed bench for mul_hilo_unit at WIDTH=8, LAT=3 with a behavioural signed multiplier.
module tb_mul_hilo_unit;

   localparam int W = 8;
   localparam int L = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [2:0]     op;
   logic [W-1:0]   src_a, src_b;
   logic [W-1:0]   mul_a, mul_b;
   logic [2*W-1:0] mul_c;
   logic           busy, done;
   logic [W-1:0]   hi, lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mul_c = $signed(mul_a) * $signed(mul_b);

   mul_hilo_unit #(.WIDTH(W), .LAT(L)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b),
      .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   typedef struct {
      string        name;
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
      int           exp_busy;
      int           exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input int eb, input int ed);
      vec_t v;
      v.name = nm; v.op = o; v.a = a; v.b = b;
      v.exp_hi = eh; v.exp_lo = el; v.exp_busy = eb; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   // One-cycle request, then observe an 8-cycle window from the accepting edge.
   task automatic run_vec(input vec_t v);
      int nb, nd;
      @(negedge clk);
      start = 1'b1; op = v.op; src_a = v.a; src_b = v.b;
      @(posedge clk); #1;
      start = 1'b0;
      if (v.exp_busy > 0) begin
         check({v.name, " mul_a"}, 32'(mul_a), 32'(v.a));
         check({v.name, " mul_b"}, 32'(mul_b), 32'(v.b));
      end
      nb = 0; nd = 0;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         nb += int'(busy);
         nd += int'(done);
      end
      check({v.name, " busy cycles"}, 32'(nb), 32'(v.exp_busy));
      check({v.name, " done pulses"}, 32'(nd), 32'(v.exp_done));
      check({v.name, " hi"}, 32'(hi), 32'(v.exp_hi));
      check({v.name, " lo"}, 32'(lo), 32'(v.exp_lo));
   endtask

   initial begin
      int nd;
      rst = 1'b1; start = 1'b0; op = 3'b000; src_a = '0; src_b = '0;

      add_vec("mult_neg",    3'b000, 8'hFD, 8'h05, 8'hFF, 8'hF1, L, 1);
      add_vec("mult_pos",    3'b000, 8'h07, 8'h06, 8'h00, 8'h2A, L, 1);
      add_vec("mult_maxpos", 3'b000, 8'h7F, 8'h7F, 8'h3F, 8'h01, L, 1);
      add_vec("mult_minmin", 3'b000, 8'h80, 8'h80, 8'h40, 8'h00, L, 1);
      add_vec("mult_minmax", 3'b000, 8'h80, 8'h7F, 8'hC0, 8'h80, L, 1);
      add_vec("mult_m1m1",   3'b000, 8'hFF, 8'hFF, 8'h00, 8'h01, L, 1);
      add_vec("mthi",        3'b001, 8'h12, 8'hAA, 8'h12, 8'h01, 0, 0);
      add_vec("mtlo",        3'b010, 8'h34, 8'hAA, 8'h12, 8'h34, 0, 0);
      add_vec("op_111",      3'b111, 8'h55, 8'h55, 8'h12, 8'h34, 0, 0);
`ifdef MUL_MADD_EN
      add_vec("madd_prep_hi", 3'b001, 8'h00, 8'h00, 8'h00, 8'h34, 0, 0);
      add_vec("madd_prep_lo", 3'b010, 8'h10, 8'h00, 8'h00, 8'h10, 0, 0);
      add_vec("madd_4x4",     3'b011, 8'h04, 8'h04, 8'h00, 8'h20, L, 1);
      add_vec("madd_ff_hi",   3'b001, 8'hFF, 8'h00, 8'hFF, 8'h20, 0, 0);
      add_vec("madd_ff_lo",   3'b010, 8'hFF, 8'h00, 8'hFF, 8'hFF, 0, 0);
      add_vec("madd_wrap",    3'b011, 8'h01, 8'h01, 8'h00, 8'h00, L, 1);
      add_vec("madd_neg",     3'b011, 8'hFD, 8'h05, 8'hFF, 8'hF1, L, 1);
`else
      add_vec("op_011_off",   3'b011, 8'h04, 8'h04, 8'h12, 8'h34, 0, 0);
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset hi", 32'(hi), 32'd0);
      check("reset lo", 32'(lo), 32'd0);
      check("reset mul_a", 32'(mul_a), 32'd0);
      check("reset mul_b", 32'(mul_b), 32'd0);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Second request one cycle into CALC must be dropped.
      @(negedge clk);
      start = 1'b1; op = 3'b000; src_a = 8'h07; src_b = 8'h06;
      @(posedge clk); #1;
      src_a = 8'h02; src_b = 8'h02;
      nd = 0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         nd += int'(done);
      end
      check("ignore2nd done pulses", 32'(nd), 32'd1);
      check("ignore2nd hi", 32'(hi), 32'h00);
      check("ignore2nd lo", 32'(lo), 32'h2A);
      check("ignore2nd mul_a", 32'(mul_a), 32'h07);

      // Request held into DONE is accepted at E+LAT+1.
      @(negedge clk);
      start = 1'b1; op = 3'b000; src_a = 8'h03; src_b = 8'h03;
      @(posedge clk); #1;
      repeat (L) @(posedge clk);
      #1;
      check("b2b first done", 32'(done), 32'd1);
      check("b2b first lo", 32'({hi, lo}), 32'h0009);
      @(negedge clk);
      src_a = 8'h02; src_b = 8'h05;
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b second busy", 32'(busy), 32'd1);
      check("b2b second mul_a", 32'(mul_a), 32'h02);
      check("b2b second mul_b", 32'(mul_b), 32'h05);
      repeat (L) @(posedge clk);
      #1;
      check("b2b second done", 32'(done), 32'd1);
      check("b2b second hilo", 32'({hi, lo}), 32'h000A);

      // Consecutive-cycle moves leave the multiplier operands alone.
      @(negedge clk);
      start = 1'b1; op = 3'b001; src_a = 8'h12; src_b = 8'h99;
      @(negedge clk);
      op = 3'b010; src_a = 8'h34;
      @(negedge clk);
      start = 1'b0;
      check("moves hi", 32'(hi), 32'h12);
      check("moves lo", 32'(lo), 32'h34);
      check("moves busy", 32'(busy), 32'd0);
      check("moves done", 32'(done), 32'd0);
      check("moves mul_a", 32'(mul_a), 32'h02);
      check("moves mul_b", 32'(mul_b), 32'h05);

      // Reset sampled in the second CALC cycle aborts the multiply.
      @(negedge clk);
      start = 1'b1; op = 3'b000; src_a = 8'h05; src_b = 8'h05;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort hi", 32'(hi), 32'd0);
      check("abort lo", 32'(lo), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         nd += int'(done) + int'(busy);
      end
      check("abort no late activity", 32'(nd), 32'd0);
      check("abort hilo held", 32'({hi, lo}), 32'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
